// File: rtl/dbg_run_ctrl_if.sv
// Command channel between the serial debug unit (master) and the run/step controller (slave).
interface dbg_run_ctrl_if;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        cmd_ready;
  logic        cmd_err;

  modport master (output cmd_valid, cmd_op, cmd_idx, cmd_arg, input cmd_ready, cmd_err);
  modport slave  (input cmd_valid, cmd_op, cmd_idx, cmd_arg, output cmd_ready, cmd_err);
endinterface

// File: rtl/dbg_run_ctrl.sv
// Run/step/halt controller for the multi-cycle CPU: clock-enable generation, PC breakpoints,
// saturating cycle counter and a halt-time snapshot of debug channels.
module dbg_run_ctrl #(
  parameter int NBP    = 4,
  parameter int CNT_W  = 32,
  parameter int DBG_CH = 8,
  parameter int DBG_W  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  dbg_run_ctrl_if.slave           cmd,
  input  logic [31:0]             pc,
  input  logic                    stop,
  output logic                    cpu_en,
  output logic                    halted,
  output logic [1:0]              halt_cause,
  output logic [3:0]              bp_hit,
  output logic [CNT_W-1:0]        cyc_cnt,
  input  logic [DBG_CH*DBG_W-1:0] dbg_in,
  input  logic [3:0]              dbg_sel,
  output logic [DBG_W-1:0]        dbg_out
);
  typedef enum logic [1:0] {ST_HALTED, ST_STEPPING, ST_RUNNING} state_t;

  localparam logic [2:0] OP_STEP = 3'd1, OP_RUN = 3'd2, OP_HALT = 3'd3,
                         OP_SET_BP = 3'd4, OP_CLR_BP = 3'd5, OP_CLR_CNT = 3'd6, OP_BAD = 3'd7;

  state_t           state_reg;
  logic [CNT_W-1:0] step_left_reg;
  logic [CNT_W-1:0] cyc_cnt_reg;
  logic             skip_reg;
  logic [1:0]       halt_cause_reg;
  logic [3:0]       bp_hit_reg;
  logic             cmd_err_reg;
  logic [31:0]      bp_addr_reg [NBP];
  logic             bp_en_reg   [NBP];
  logic [DBG_W-1:0] snap_reg    [DBG_CH];

  logic [NBP-1:0]   bp_match;
  logic             any_match;
  logic [3:0]       match_idx;
  logic             bp_match_eff;
  logic             halt_now;
  logic [1:0]       cause_next;
  logic             err_now;
  logic [CNT_W-1:0] step_arg;

  wire op_step   = cmd.cmd_valid && (cmd.cmd_op == OP_STEP);
  wire op_run    = cmd.cmd_valid && (cmd.cmd_op == OP_RUN);
  wire op_halt   = cmd.cmd_valid && (cmd.cmd_op == OP_HALT);
  wire op_bp     = cmd.cmd_valid && ((cmd.cmd_op == OP_SET_BP) || (cmd.cmd_op == OP_CLR_BP));
  wire op_clrcnt = cmd.cmd_valid && (cmd.cmd_op == OP_CLR_CNT);
  wire idx_ok    = (32'(cmd.cmd_idx) < NBP);

  assign step_arg = cmd.cmd_arg[CNT_W-1:0];

  // Breakpoint registers; an out-of-range index matches no slot and is flagged as an error.
  for (genvar gi = 0; gi < NBP; gi++) begin : g_bp
    assign bp_match[gi] = bp_en_reg[gi] && (bp_addr_reg[gi] == pc);
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        bp_addr_reg[gi] <= '0;
        bp_en_reg[gi]   <= 1'b0;
      end else if (op_bp && (cmd.cmd_idx == 4'(gi))) begin
        if (cmd.cmd_op == OP_SET_BP) begin
          bp_addr_reg[gi] <= cmd.cmd_arg;
          bp_en_reg[gi]   <= 1'b1;
        end else begin
          bp_en_reg[gi]   <= 1'b0;
        end
      end
    end
  end

  // Descending scan so the lowest matching index is the one reported.
  always_comb begin
    any_match = 1'b0;
    match_idx = '0;
    for (int i = NBP - 1; i >= 0; i--) begin
      if (bp_match[i]) begin
        any_match = 1'b1;
        match_idx = 4'(i);
      end
    end
  end

  assign bp_match_eff = any_match && !skip_reg;
  assign cpu_en = (state_reg != ST_HALTED) && !stop && !bp_match_eff &&
                  !((state_reg == ST_STEPPING) && (step_left_reg == '0));

  // Halt arbitration; the earlier branches already exclude stop/bp, so step_left==1 means a live step.
  always_comb begin
    halt_now   = 1'b0;
    cause_next = halt_cause_reg;
    if (state_reg != ST_HALTED) begin
      if (stop) begin
        halt_now   = 1'b1;
        cause_next = 2'd3;
      end else if (bp_match_eff) begin
        halt_now   = 1'b1;
        cause_next = 2'd2;
      end else if ((state_reg == ST_STEPPING) && (step_left_reg <= CNT_W'(1))) begin
        halt_now   = 1'b1;
        cause_next = 2'd1;
      end else if (op_halt) begin
        halt_now   = 1'b1;
        cause_next = 2'd0;
      end
    end
  end

  assign err_now = cmd.cmd_valid &&
                   ((cmd.cmd_op == OP_BAD) || (op_bp && !idx_ok) ||
                    ((op_step || op_run) && (state_reg != ST_HALTED)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= ST_HALTED;
      step_left_reg  <= '0;
      cyc_cnt_reg    <= '0;
      skip_reg       <= 1'b0;
      halt_cause_reg <= 2'd0;
      bp_hit_reg     <= 4'd0;
      cmd_err_reg    <= 1'b0;
    end else begin
      cmd_err_reg <= err_now;
      if (op_clrcnt) begin
        cyc_cnt_reg <= '0;
      end else if (cpu_en && !(&cyc_cnt_reg)) begin
        cyc_cnt_reg <= cyc_cnt_reg + CNT_W'(1);
      end
      if (cpu_en) begin
        skip_reg <= 1'b0;
      end
      if ((state_reg == ST_STEPPING) && cpu_en) begin
        step_left_reg <= step_left_reg - CNT_W'(1);
      end
      case (state_reg)
        ST_HALTED: begin
          if (op_step) begin
            state_reg     <= ST_STEPPING;
            step_left_reg <= (step_arg == '0) ? CNT_W'(1) : step_arg;
            skip_reg      <= 1'b1;
          end else if (op_run) begin
            state_reg <= ST_RUNNING;
            skip_reg  <= 1'b1;
          end
        end
        default: begin
          if (halt_now) begin
            state_reg      <= ST_HALTED;
            halt_cause_reg <= cause_next;
            if (cause_next == 2'd2) begin
              bp_hit_reg <= match_idx;
            end
          end
        end
      endcase
    end
  end

  // Snapshot is taken on exactly the edge that moves the FSM into HALTED.
  for (genvar gi = 0; gi < DBG_CH; gi++) begin : g_snap
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        snap_reg[gi] <= '0;
      end else if (halt_now) begin
        snap_reg[gi] <= dbg_in[gi*DBG_W +: DBG_W];
      end
    end
  end

  always_comb begin
    dbg_out = '0;
    for (int k = 0; k < DBG_CH; k++) begin
      if (dbg_sel == 4'(k)) begin
        dbg_out = snap_reg[k];
      end
    end
  end

  assign halted        = (state_reg == ST_HALTED);
  assign halt_cause    = halt_cause_reg;
  assign bp_hit        = bp_hit_reg;
  assign cyc_cnt       = cyc_cnt_reg;
  assign cmd.cmd_ready = 1'b1;
  assign cmd.cmd_err   = cmd_err_reg;
endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Scoreboard bench for dbg_run_ctrl: stimulus queues expectations, a negedge monitor pops and compares.
module tb_dbg_run_ctrl;
  localparam int NBP = 4, CNT_W = 4, DBG_CH = 8, DBG_W = 16;
  localparam logic [2:0] OP_STEP = 3'd1, OP_RUN = 3'd2, OP_HALT = 3'd3,
                         OP_SET_BP = 3'd4, OP_CLR_BP = 3'd5, OP_CLR_CNT = 3'd6;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  dbg_run_ctrl_if cif ();
  logic [31:0]             pc;
  logic                    stop;
  logic                    cpu_en;
  logic                    halted;
  logic [1:0]              halt_cause;
  logic [3:0]              bp_hit;
  logic [CNT_W-1:0]        cyc_cnt;
  logic [DBG_CH*DBG_W-1:0] dbg_in;
  logic [3:0]              dbg_sel;
  logic [DBG_W-1:0]        dbg_out;

  dbg_run_ctrl #(.NBP(NBP), .CNT_W(CNT_W), .DBG_CH(DBG_CH), .DBG_W(DBG_W)) dut (
    .clk(clk), .rstn(rstn), .cmd(cif.slave), .pc(pc), .stop(stop), .cpu_en(cpu_en),
    .halted(halted), .halt_cause(halt_cause), .bp_hit(bp_hit), .cyc_cnt(cyc_cnt),
    .dbg_in(dbg_in), .dbg_sel(dbg_sel), .dbg_out(dbg_out)
  );

  // sel: 0 halted, 1 cpu_en, 2 cyc_cnt, 3 dbg_out, 4 halt_cause, 5 bp_hit
  typedef struct { string name; int sel; logic [31:0] exp; } probe_t;
  // negative bp/pulses/cyc fields mean "don't care"
  typedef struct { string name; logic [1:0] cause; int bp; int pulses; int cyc; } halt_t;

  probe_t probe_q[$];
  halt_t  halt_q[$];
  string  err_q[$];

  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  bit   auto_pc = 1'b0;
  logic halted_prev = 1'b1;
  int   pulses = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic logic [31:0] sel_val(input int sel);
    case (sel)
      0:       return 32'(halted);
      1:       return 32'(cpu_en);
      2:       return 32'(cyc_cnt);
      3:       return 32'(dbg_out);
      4:       return 32'(halt_cause);
      default: return 32'(bp_hit);
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    probe_t p;
    halt_t  h;
    string  e;
    if (mon_en) begin
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        check(p.name, sel_val(p.sel), p.exp);
      end
      if (cpu_en) pulses++;
      if (halted && !halted_prev) begin
        if (halt_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_halt: got cause %0d, expected no halt", halt_cause);
        end else begin
          h = halt_q.pop_front();
          check({h.name, "_cause"}, 32'(halt_cause), 32'(h.cause));
          if (h.bp >= 0)     check({h.name, "_bp_hit"}, 32'(bp_hit), h.bp);
          if (h.pulses >= 0) check({h.name, "_pulses"}, pulses, h.pulses);
          if (h.cyc >= 0)    check({h.name, "_cyc_cnt"}, 32'(cyc_cnt), h.cyc);
        end
        pulses = 0;
      end
      if (cif.cmd_err) begin
        if (err_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_cmd_err: got 1, expected 0");
        end else begin
          e = err_q.pop_front();
          check(e, 32'(cif.cmd_err), 32'd1);
        end
      end
    end
    halted_prev = halted;
  end

  // One cycle; a simple CPU model advances pc by 4 for every enabled cycle.
  task automatic tick();
    logic en_s;
    @(negedge clk);
    en_s = cpu_en;
    @(posedge clk);
    #1;
    if (auto_pc && en_s) pc = pc + 32'd4;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] idx, input logic [31:0] arg);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_idx   = idx;
    cif.cmd_arg   = arg;
    tick();
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 3'd0;
  endtask

  task automatic probe(input string name, input int sel, input logic [31:0] exp);
    probe_t p;
    p.name = name; p.sel = sel; p.exp = exp;
    probe_q.push_back(p);
  endtask

  task automatic expect_halt(input string name, input logic [1:0] cause, input int bp,
                             input int np, input int cyc);
    halt_t h;
    h.name = name; h.cause = cause; h.bp = bp; h.pulses = np; h.cyc = cyc;
    halt_q.push_back(h);
  endtask

  initial begin : stimulus
    int sels[4] = '{0, 5, 9, 15};
    cif.cmd_valid = 1'b0; cif.cmd_op = 3'd0; cif.cmd_idx = 4'd0; cif.cmd_arg = 32'd0;
    pc = 32'd0; stop = 1'b0; dbg_in = '0; dbg_sel = 4'd0;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    mon_en = 1'b1;

    probe("rst_halted", 0, 1); probe("rst_cpu_en", 1, 0);
    probe("rst_cyc_cnt", 2, 0); probe("rst_halt_cause", 4, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 4'(sels[i]);
      probe($sformatf("rst_dbg_out_sel%0d", sels[i]), 3, 0);
      tick();
    end

    auto_pc = 1'b1;
    expect_halt("step3", 2'd1, 0, 3, 3);
    send(OP_STEP, 4'd0, 32'd3);
    ticks(6);
    expect_halt("step0", 2'd1, 0, 1, 4);
    send(OP_STEP, 4'd0, 32'd0);
    ticks(4);

    pc = 32'd0;
    send(OP_SET_BP, 4'd2, 32'h1C);
    send(OP_CLR_CNT, 4'd0, 32'd0);
    expect_halt("bp2", 2'd2, 2, 7, 7);
    send(OP_RUN, 4'd0, 32'd0);
    ticks(12);
    probe("bp_cpu_en_low", 1, 0);
    tick();
    send(OP_RUN, 4'd0, 32'd0);
    probe("skip_cpu_en_high", 1, 1);
    tick();

    auto_pc = 1'b0;
    pc = 32'h200;
    tick();
    err_q.push_back("run_while_running_err");
    send(OP_RUN, 4'd0, 32'd0);
    send(OP_SET_BP, 4'd0, 32'h300);
    dbg_in[5*DBG_W +: DBG_W] = 16'hBEEF;
    dbg_in[0 +: DBG_W]       = 16'h0A0A;
    expect_halt("stop_vs_bp", 2'd3, -1, -1, -1);
    pc = 32'h300; stop = 1'b1;
    tick();
    ticks(2);
    probe("stop_while_halted_halted", 0, 1);
    probe("stop_while_halted_cause", 4, 3);
    probe("stop_while_halted_cpu_en", 1, 0);
    tick();
    stop = 1'b0;
    dbg_in[5*DBG_W +: DBG_W] = 16'h1234;
    tick();
    dbg_sel = 4'd5; probe("snap_ch5", 3, 32'hBEEF); tick();
    dbg_sel = 4'd9; probe("snap_sel9_zero", 3, 0); tick();
    dbg_sel = 4'd0; probe("snap_ch0", 3, 32'h0A0A); tick();

    err_q.push_back("illegal_op_err");
    send(3'd7, 4'd0, 32'd0);
    err_q.push_back("bad_idx_err");
    send(OP_SET_BP, 4'd5, 32'd0);
    send(OP_HALT, 4'd0, 32'd0);
    tick();

    send(OP_CLR_BP, 4'd0, 32'd0);
    send(OP_CLR_BP, 4'd2, 32'd0);
    pc = 32'h100; auto_pc = 1'b1;
    send(OP_CLR_CNT, 4'd0, 32'd0);
    send(OP_RUN, 4'd0, 32'd0);
    ticks(20);
    probe("sat_cyc_cnt", 2, 15); probe("sat_cpu_en", 1, 1);
    tick();
    err_q.push_back("step_while_running_err");
    send(OP_STEP, 4'd0, 32'd2);
    send(OP_CLR_CNT, 4'd0, 32'd0);
    probe("clr_cnt_wins", 2, 0);
    tick();
    probe("clr_cnt_then_inc", 2, 1);
    expect_halt("halt_cmd", 2'd0, -1, -1, 2);
    send(OP_HALT, 4'd0, 32'd0);
    tick();
    send(OP_HALT, 4'd0, 32'd0);
    tick();

    send(OP_RUN, 4'd0, 32'd0);
    ticks(3);
    expect_halt("async_rst", 2'd0, 0, -1, 0);
    rstn = 1'b0;
    probe("rst_mid_cpu_en", 1, 0); probe("rst_mid_halted", 0, 1); probe("rst_mid_cyc_cnt", 2, 0);
    tick();
    rstn = 1'b1;
    ticks(3);

    check("halt_q_drained", halt_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    check("probe_q_drained", probe_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
